// File: rtl/neuron_lut_loader.sv
// Run-time loadable truth-table neuron: a streamed table of 2^IN_BITS entries of OUT_BITS each,
// read through a registered M0 -> M1 lookup port.
module neuron_lut_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [LOAD_W-1:0]   load_data,
    input  logic                load_valid,
    output logic                load_ready,
    output logic                load_done,
    output logic                busy,
    output logic                table_valid,
    input  logic [IN_BITS-1:0]  M0,
    input  logic                M0_valid,
    output logic [OUT_BITS-1:0] M1,
    output logic                M1_valid,
    output logic [1:0]          dbg_state
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int TBL_W = DEPTH * OUT_BITS;
    localparam int BEATS = TBL_W / LOAD_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (TBL_W > 1) ? $clog2(TBL_W) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Load handshake: a beat transfers on any cycle where load_valid and load_ready are both high.
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [TBL_W-1:0]   ram_q, ram_d;
    logic [OUT_BITS-1:0] m1_q, m1_d;
    logic               m1_valid_q, m1_valid_d;

    logic               beat_accept;
    logic               last_beat;
    logic [IDX_W-1:0]   wr_base;
    logic [IDX_W-1:0]   rd_base;

    assign beat_accept = (state_q == ST_LOAD) && load_valid;
    assign last_beat   = beat_accept && (cnt_q == CNT_W'(BEATS - 1));
    assign wr_base     = IDX_W'(cnt_q) * IDX_W'(LOAD_W);
    assign rd_base     = IDX_W'(M0) * IDX_W'(OUT_BITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            m1_q       <= '0;
            m1_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            m1_q       <= m1_d;
            m1_valid_q <= m1_valid_d;
        end
    end

    // Table storage is deliberately left out of reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        ram_q <= ram_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_EMPTY, ST_READY: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (beat_accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_beat) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_ready  = (state_q == ST_LOAD);
        busy        = (state_q == ST_LOAD);
        table_valid = (state_q == ST_READY);
        load_done   = done_q;
        dbg_state   = state_q;
    end

    always_comb begin
        ram_d = ram_q;
        if (beat_accept) begin
            ram_d[wr_base +: LOAD_W] = load_data;
        end
    end

    // A lookup only sees table contents once the table is fully resident; otherwise it returns zero.
    always_comb begin
        m1_d       = m1_q;
        m1_valid_d = M0_valid;
        if (M0_valid) begin
            m1_d = (state_q == ST_READY) ? ram_q[rd_base +: OUT_BITS] : '0;
        end
    end

    assign M1       = m1_q;
    assign M1_valid = m1_valid_q;

endmodule

// File: doc/neuron_lut_loader.md
Name: neuron_lut_loader

Overview:
- Run-time loadable counterpart to the fixed truth-table neurons: a 2^IN_BITS x OUT_BITS distributed-RAM LUT.
- A streaming loader writes the table. The inference side reads it with the same M0 -> M1 lookup interface the ROM neurons use, but the output is registered.
- Used on the layer-4 path so retrained neuron tables can be swapped in without resynthesis.

Parameters:
- IN_BITS, 8, lookup address width (fan-in bits); DEPTH = 2^IN_BITS.
- OUT_BITS, 1, width of each table entry.
- LOAD_W, 8, bits per load beat. DEPTH*OUT_BITS must be a multiple of LOAD_W; BEATS = DEPTH*OUT_BITS/LOAD_W (32 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- load_start  in  1  begin a table load
- load_data  in  LOAD_W  table bits for the current beat
- load_valid  in  1  load_data is valid
- load_ready  out  1  loader accepts a beat this cycle
- load_done  out  1  one-cycle pulse when the last beat is written
- busy  out  1  a load is in progress
- table_valid  out  1  a complete table is resident
- M0  in  IN_BITS  lookup address (unsigned entry index)
- M0_valid  in  1  lookup request
- M1  out  OUT_BITS  looked-up entry, registered
- M1_valid  out  1  M1 is valid this cycle

Behaviour:
- Single clock domain. All state changes on the rising clk edge.
- Reset values: load_ready=0, load_done=0, busy=0, table_valid=0, M1=0, M1_valid=0, beat counter=0, FSM=EMPTY. RAM contents are not reset.
- FSM states:
  - EMPTY: no valid table.
  - READY: table resident.
  - LOAD: load in progress.
- FSM transitions:
  - EMPTY or READY with load_start=1 -> LOAD. Next cycle: beat counter=0, table_valid=0, busy=1.
  - LOAD: load_ready=1. Each cycle with load_valid&load_ready writes one beat and increments the counter.
  - LOAD, beat BEATS-1 accepted -> READY. Next cycle: table_valid=1, busy=0, load_ready=0, load_done=1 for exactly one cycle.
  - load_start while in LOAD is ignored; the counter is not restarted.
  - load_valid outside LOAD is ignored; load_ready=0 there.
- Beat packing: beat k, bit j (j=0..LOAD_W-1) goes to flat bit position p=k*LOAD_W+j. Entry index = p/OUT_BITS; bit within entry = p mod OUT_BITS. The lowest address is filled first, LSB first.
- Gaps: load_valid may deassert for any number of cycles mid-load. The counter holds during gaps.
- Lookup:
  - Latency 1: M0_valid at cycle t gives M1_valid=1 at t+1.
  - M1 = table[M0] when table_valid=1 at cycle t. Otherwise M1=0 (covers EMPTY, mid-load, and after reset).
  - M1 holds its last value when M0_valid=0; M1_valid=0 that cycle.
  - Lookups are accepted every cycle and never stall.
- Simultaneous lookup and final beat: the lookup sees table_valid=0 and returns 0. The first lookup issued in the cycle after load_done is high returns new contents.
- Reset mid-load: return to EMPTY and drop the partial load. table_valid stays 0 until a full new load completes.
- Reload from READY: table_valid drops the cycle after load_start is accepted. Old contents are no longer observable.

Test Plan:
- Lookup before any load: M0=8'h00 and M0=8'hFF with M0_valid=1 -> M1_valid=1 next cycle, M1=0, table_valid=0.
- Back-to-back load at defaults: 32 beats of load_data=8'hA5 -> load_done pulses once, table_valid=1. Then lookup addresses 0,1,2,5,7,255 -> M1 = 1,0,1,1,1,1 (bit 255 is bit 7 of 8'hA5 = 1).
- Gapped load: same data with load_valid toggling 1,0,0,1 -> load_done fires only after the 32nd accepted beat; lookup results are identical to the back-to-back case.
- Reset mid-load: assert rst after 10 beats -> busy=0, load_ready=0, table_valid=0. A following lookup at M0=8'h00 returns M1=0.
- Spurious start during load: load_start pulsed at beat 15 -> load completes after beat 31 with no restart; load_done occurs exactly once.
- Lookup concurrent with final beat: M0_valid with M0=8'h00 in the cycle the last beat is accepted -> M1=0. The same address one cycle after load_done -> M1 equals the new table[0].
